mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, 64, address width.
REQ-002 Parameter DW, 64, data width.
REQ-003 Parameter STARVE_LIMIT, 4, maximum consecutive data grants while fetch pending; legal range 1..15.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ireq_valid  in  1  fetch request pending; held high until iresp_valid.
REQ-007 ireq_addr  in  AW  fetch address.
REQ-008 dreq_valid  in  1  data request pending; held high until dresp_valid.
REQ-009 dreq_addr  in  AW  data address.
REQ-010 dreq_strobe  in  DW/8  byte write enables; all-zero means read.
REQ-011 dreq_wdata  in  DW  store data.
REQ-012 oreq_valid  out  1  shared-port request.
REQ-013 oreq_addr / oreq_strobe / oreq_wdata  out  AW / DW/8 / DW  latched request fields.
REQ-014 oresp_valid  in  1  shared-port completion, one-cycle pulse.
REQ-015 oresp_rdata  in  DW  read data, valid with oresp_valid.
REQ-016 iresp_valid / dresp_valid  out  1 each  completion to owner.
REQ-017 iresp_rdata / dresp_rdata  out  DW each  oresp_rdata forwarded.
REQ-018 imem_wait / dmem_wait  out  1 each  stall indications to the hazard unit.

Function
REQ-019 FSM states IDLE, BUSY_I, BUSY_D; the arbiter SHALL be in exactly one state at any time.
REQ-020 IDLE: if neither request is valid, the arbiter SHALL stay in IDLE.
REQ-021 IDLE: default priority data over fetch; the arbiter SHALL grant data when dreq_valid, else fetch when ireq_valid.
REQ-022 Anti-starvation override: if both requests are valid and starve_cnt == STARVE_LIMIT, the arbiter SHALL grant fetch.
REQ-023 On a grant, the arbiter SHALL register the winner's addr, strobe and wdata into the oreq_* registers; fetch grants SHALL register strobe as 0 and wdata as 0.
REQ-024 On a grant, the FSM SHALL move to BUSY_I or BUSY_D on the next edge.
REQ-025 oreq_valid SHALL be 1 exactly while in BUSY_I or BUSY_D; oreq_* SHALL remain stable throughout BUSY.
REQ-026 In BUSY_x with oresp_valid=1, the arbiter SHALL drive x_resp_valid=1 combinationally in that cycle and return to IDLE on the next edge.
REQ-027 In BUSY_x with oresp_valid=1, the arbiter SHALL drive the non-owner resp_valid to 0.
REQ-028 oresp_valid in IDLE SHALL be ignored: no resp_valid, no state change.
REQ-029 Minimum transaction latency SHALL be 2 cycles: grant cycle, then a BUSY cycle in which the response is accepted. The next grant SHALL occur no earlier than the cycle after the response.
REQ-030 A requester dropping valid mid-transaction SHALL NOT abort it; the transaction SHALL complete and the response pulse SHALL still be issued.
REQ-031 starve_cnt (4 bits) SHALL increment on a data grant with ireq_valid=1, saturating at STARVE_LIMIT.
REQ-032 starve_cnt SHALL clear on any fetch grant and on any data grant with ireq_valid=0.
REQ-033 imem_wait SHALL equal ireq_valid & ~iresp_valid; dmem_wait SHALL equal dreq_valid & ~dresp_valid (combinational).

Reset
REQ-034 While reset=1 on a clock edge: state=IDLE, starve_cnt=0, oreq_addr/strobe/wdata=0.
REQ-035 While reset=1: oreq_valid=0, iresp_valid=0, dresp_valid=0.
REQ-036 Reset asserted mid-BUSY SHALL abandon the transaction with no response issued; a late oresp_valid arriving after reset SHALL be ignored per REQ-028.

Verification
REQ-037 Fetch only: ireq_valid=1, addr=0x8000_0000, oresp_valid one cycle after oreq_valid rises -> oreq_addr=0x8000_0000 with strobe=0, one iresp_valid pulse, dresp_valid=0.
REQ-038 Simultaneous requests: ireq and dreq asserted same cycle, dreq_strobe=0xFF -> data served first, then fetch; imem_wait=1 until fetch response.
REQ-039 Starvation, STARVE_LIMIT=4: ireq held, dreq reasserted after each response -> 4 data grants, 5th grant to fetch, starve_cnt then 0.
REQ-040 Stall on shared port: oresp_valid delayed 10 cycles -> oreq_* stable for all 10 cycles, single resp pulse.
REQ-041 Reset mid-BUSY_D, then oresp_valid pulse -> no dresp_valid, state IDLE, oreq_valid=0.
REQ-042 Spurious oresp_valid in IDLE -> no resp_valid, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto a single shared memory port.
// Data wins by default; fetch is forced through after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int AW           = 64,
  parameter int DW           = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ireq_valid,
  input  logic [AW-1:0]   ireq_addr,
  input  logic            dreq_valid,
  input  logic [AW-1:0]   dreq_addr,
  input  logic [DW/8-1:0] dreq_strobe,
  input  logic [DW-1:0]   dreq_wdata,
  output logic            oreq_valid,
  output logic [AW-1:0]   oreq_addr,
  output logic [DW/8-1:0] oreq_strobe,
  output logic [DW-1:0]   oreq_wdata,
  input  logic            oresp_valid,
  input  logic [DW-1:0]   oresp_rdata,
  output logic            iresp_valid,
  output logic [DW-1:0]   iresp_rdata,
  output logic            dresp_valid,
  output logic [DW-1:0]   dresp_rdata,
  output logic            imem_wait,
  output logic            dmem_wait
);

  localparam int SW = DW / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] oreq_addr_q, oreq_addr_d;
  logic [SW-1:0] oreq_strobe_q, oreq_strobe_d;
  logic [DW-1:0] oreq_wdata_q, oreq_wdata_d;

  logic fetch_forced;

  // Fetch only pre-empts a pending data request once the starvation counter is full.
  assign fetch_forced = ireq_valid && (starve_cnt_q == LIMIT);

  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    oreq_addr_d   = oreq_addr_q;
    oreq_strobe_d = oreq_strobe_q;
    oreq_wdata_d  = oreq_wdata_q;
    case (state_q)
      IDLE: begin
        if (dreq_valid && !fetch_forced) begin
          state_d       = BUSY_D;
          oreq_addr_d   = dreq_addr;
          oreq_strobe_d = dreq_strobe;
          oreq_wdata_d  = dreq_wdata;
          if (!ireq_valid) begin
            starve_cnt_d = 4'd0;
          end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (ireq_valid) begin
          state_d       = BUSY_I;
          oreq_addr_d   = ireq_addr;
          oreq_strobe_d = '0;
          oreq_wdata_d  = '0;
          starve_cnt_d  = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (oresp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      starve_cnt_q  <= 4'd0;
      oreq_addr_q   <= '0;
      oreq_strobe_q <= '0;
      oreq_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      oreq_addr_q   <= oreq_addr_d;
      oreq_strobe_q <= oreq_strobe_d;
      oreq_wdata_q  <= oreq_wdata_d;
    end
  end

  // Outputs are gated by reset so an in-flight transaction is dropped immediately.
  assign oreq_valid  = (state_q != IDLE) && !reset;
  assign oreq_addr   = oreq_addr_q;
  assign oreq_strobe = oreq_strobe_q;
  assign oreq_wdata  = oreq_wdata_q;

  assign iresp_valid = (state_q == BUSY_I) && oresp_valid && !reset;
  assign dresp_valid = (state_q == BUSY_D) && oresp_valid && !reset;
  assign iresp_rdata = oresp_rdata;
  assign dresp_rdata = oresp_rdata;

  assign imem_wait = ireq_valid && !iresp_valid;
  assign dmem_wait = dreq_valid && !dresp_valid;

endmodule
